uart_frame_deframer: RTL

- Sits between uart_rx (done/data_out) and uart_to_spi_bridge-style SPI issue logic.
- Hunts for framed commands on the UART byte stream: SOF, LEN, LEN payload bytes, then an XOR checksum.
- Buffers the payload and releases it only after the checksum verifies. Each payload byte is then issued to spi_master with a start/done handshake.
- Malformed frames never reach the SPI bus.

---
 rtl/uart_spi_pkg.sv | 22 ++
 rtl/frame_buf.sv | 36 +++
 rtl/uart_frame_deframer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_spi_pkg.sv
// Shared definitions for the UART framed-command to SPI path.
//   state_e      : deframer FSM states
//   ERR_*        : err_code values reported on frame rejection
//   DEFAULT_SOF_BYTE : default start-of-frame marker
package uart_spi_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array.
//   clk   : write clock
//   we    : write enable, writes wdata to waddr on the rising edge
//   waddr : write pointer (PTR_W bits, only 0..MAX_LEN-1 are ever written)
//   wdata : byte to store
//   raddr : read pointer
//   rdata : combinational read of raddr
module frame_buf #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned PTR_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [7:0]       rdata
);

    // Pointers carry one extra bit so they can hold MAX_LEN; entries only need the low bits.
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0] mem_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[raddr[IDX_W-1:0]];

    logic unused_ptr_bits;
    assign unused_ptr_bits = ^{waddr, raddr};

endmodule

// File: rtl/uart_frame_deframer.sv
// Frame hunter between uart_rx and spi_master.
// Frame: SOF, LEN, LEN payload bytes, XOR checksum (LEN ^ payload). A verified payload is
// issued to SPI one byte per start/done handshake; bad frames never reach the bus.
// Ports:
//   clk, rst (sync, active-low)
//   uart_done/uart_data : received byte strobe and value
//   spi_done            : transfer-complete strobe from spi_master
//   spi_start/spi_tx_data : transfer request and the byte, held until spi_done
//   busy      : not in HUNT
//   frame_ok  : pulse when a frame has been fully drained (or LEN=0 frame verified)
//   frame_err : pulse on rejection, cause in err_code (held until next rejection)
//   rx_drop   : pulse when a byte arrives during DRAIN and is discarded
// Optional: define UART_FRAME_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module uart_frame_deframer
    import uart_spi_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SOF_BYTE       = DEFAULT_SOF_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_done,
    input  logic [7:0] uart_data,
    input  logic       spi_done,
    output logic       spi_start,
    output logic [7:0] spi_tx_data,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       rx_drop
);

    localparam int unsigned PTR_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] len_q, len_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       csum_q, csum_d;
    logic             issue_q, issue_d;   // first cycle of DRAIN: issue byte 0
    logic             spi_start_q, spi_start_d;
    logic [7:0]       spi_tx_data_q, spi_tx_data_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             rx_drop_q, rx_drop_d;
    logic             drain_ok;
    logic             buf_we;
    logic [7:0]       buf_rdata;
    logic             tmo_hit;

    frame_buf #(
        .MAX_LEN (MAX_LEN),
        .PTR_W   (PTR_W)
    ) u_frame_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_q),
        .wdata (uart_data),
        .raddr (rd_ptr_d),
        .rdata (buf_rdata)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             in_frame;

    // Every entry into LEN/PAYLOAD/CSUM happens on uart_done, so clearing on uart_done
    // also covers the clear-on-entry case.
    always_comb begin
        in_frame  = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
        tmo_cnt_d = (in_frame && !uart_done) ? tmo_cnt_q + 1'b1 : '0;
        tmo_hit   = in_frame && !uart_done && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;

    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        csum_d      = csum_q;
        issue_d     = 1'b0;
        spi_start_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        rx_drop_d   = 1'b0;
        drain_ok    = 1'b0;
        buf_we      = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (uart_done && uart_data == SOF_BYTE) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (uart_done) begin
                    csum_d   = uart_data;
                    wr_ptr_d = '0;
                    if (uart_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = HUNT;
                    end else begin
                        len_d   = uart_data[PTR_W-1:0];
                        state_d = (uart_data == 8'h00) ? CSUM : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (uart_done) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    csum_d   = csum_q ^ uart_data;
                    if (wr_ptr_d == len_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (uart_done) begin
                    if (uart_data != csum_q) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = HUNT;
                    end else if (len_q == '0) begin
                        frame_ok_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        rd_ptr_d = '0;
                        issue_d  = 1'b1;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                rx_drop_d = uart_done;
                if (issue_q) begin
                    spi_start_d = 1'b1;
                end else if (spi_done) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_d == len_q) begin
                        drain_ok = 1'b1;
                        state_d  = HUNT;
                    end else begin
                        spi_start_d = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = HUNT;
        end

        // rd_ptr_d already points at the byte to send, so the read is ready this cycle.
        spi_tx_data_d = spi_start_d ? buf_rdata : spi_tx_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= HUNT;
            len_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            csum_q        <= '0;
            issue_q       <= 1'b0;
            spi_start_q   <= 1'b0;
            spi_tx_data_q <= 8'h00;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            rx_drop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            csum_q        <= csum_d;
            issue_q       <= issue_d;
            spi_start_q   <= spi_start_d;
            spi_tx_data_q <= spi_tx_data_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            rx_drop_q     <= rx_drop_d;
        end
    end

    assign spi_start   = spi_start_q;
    assign spi_tx_data = spi_tx_data_q;
    assign busy        = (state_q != HUNT);
    // Drain completion is flagged in the same cycle as the final spi_done.
    assign frame_ok    = frame_ok_q | drain_ok;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign rx_drop     = rx_drop_q;

endmodule
